// File: rtl/obstacle_feeder.sv
// Scrolling obstacle column generator with LFSR gap heights and spacing ramp.
// Ports: clk/reset (sync, active-high), start/stop pulses, 16-bit seed;
//   col_data/col_valid/col_ready FWFT stream; pipe_count, cur_spacing, busy.
module obstacle_feeder #(
    parameter int SPACING     = 6,
    parameter int MIN_SPACING = 3,
    parameter int RAMP_EVERY  = 8,
    parameter int GAP_MIN     = 8,
    parameter int GAP_MAX     = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] seed,
    output logic [6:0]  col_data,
    output logic        col_valid,
    input  logic        col_ready,
    output logic [15:0] pipe_count,
    output logic [3:0]  cur_spacing,
    output logic        busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    state_t      state_q, state_d;
    logic [6:0]  mem_q [4];
    logic [6:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] pipe_count_q, pipe_count_d;
    logic [3:0]  col_idx_q, col_idx_d;
    logic [3:0]  spacing_q, spacing_d;
    logic [7:0]  ramp_q, ramp_d;

    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic        is_pipe;
    logic [6:0]  raw;
    logic [6:0]  code;
    logic [6:0]  push_data;
    logic [15:0] lfsr_next;
    logic [7:0]  ramp_next;

    always_comb begin
        full      = (cnt_q == 3'd4);
        empty     = (cnt_q == 3'd0);
        pop       = !empty && col_ready;
        is_pipe   = (col_idx_q == spacing_q - 4'd1);
        raw       = lfsr_q[6:0];
        lfsr_next = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        ramp_next = ramp_q + 8'd1;
        if (raw < 7'(GAP_MIN)) begin
            code = 7'(GAP_MIN);
        end else if (raw > 7'(GAP_MAX)) begin
            code = 7'(GAP_MAX);
        end else begin
            code = raw;
        end

        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        lfsr_d       = lfsr_q;
        pipe_count_d = pipe_count_q;
        col_idx_d    = col_idx_q;
        spacing_d    = spacing_q;
        ramp_d       = ramp_q;
        push         = 1'b0;
        push_data    = 7'd0;

        if (start) begin
            state_d      = RUN;
            lfsr_d       = (seed == 16'd0) ? LFSR_INIT : seed;
            wr_ptr_d     = 2'd0;
            rd_ptr_d     = 2'd0;
            cnt_d        = 3'd0;
            col_idx_d    = 4'd0;
            ramp_d       = 8'd0;
            pipe_count_d = 16'd0;
            spacing_d    = 4'(SPACING);
        end else if (stop) begin
            state_d  = IDLE;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            cnt_d    = 3'd0;
        end else begin
            // Full is the registered count, so a pop this cycle
            // cannot open a slot for a push in the same cycle.
            push = (state_q == RUN) && !full;
            if (push) begin
                if (is_pipe) begin
                    push_data = code;
                    col_idx_d = 4'd0;
                    lfsr_d    = lfsr_next;
                    if (pipe_count_q != 16'hFFFF) begin
                        pipe_count_d = pipe_count_q + 16'd1;
                    end
                    if (ramp_next == 8'(RAMP_EVERY)) begin
                        ramp_d = 8'd0;
                        if (spacing_q > 4'(MIN_SPACING)) begin
                            spacing_d = spacing_q - 4'd1;
                        end
                    end else begin
                        ramp_d = ramp_next;
                    end
                end else begin
                    push_data = 7'd0;
                    col_idx_d = col_idx_q + 4'd1;
                end
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 3'd1;
                2'b01:   cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 7'd0;
            end
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            cnt_q        <= 3'd0;
            lfsr_q       <= LFSR_INIT;
            pipe_count_q <= 16'd0;
            col_idx_q    <= 4'd0;
            spacing_q    <= 4'(SPACING);
            ramp_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            pipe_count_q <= pipe_count_d;
            col_idx_q    <= col_idx_d;
            spacing_q    <= spacing_d;
            ramp_q       <= ramp_d;
        end
    end

    // Head is gated so an empty FIFO always presents code 0.
    assign col_valid   = !empty;
    assign col_data    = empty ? 7'd0 : mem_q[rd_ptr_q];
    assign pipe_count  = pipe_count_q;
    assign cur_spacing = spacing_q;
    assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_obstacle_feeder.sv
// Bench for obstacle_feeder: column stream compared against a reference
// generator queue, plus directed checks on stall, stop, restart and reset.
module tb_obstacle_feeder;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] seed;
    logic [6:0]  col_data;
    logic        col_valid;
    logic        col_ready;
    logic [15:0] pipe_count;
    logic [3:0]  cur_spacing;
    logic        busy;

    int total;
    int bad;

    logic [6:0]  expq [$];
    logic [15:0] m_lfsr;
    int          m_idx;
    int          m_sp;
    int          m_ramp;
    logic        popped;
    logic [6:0]  last_pop;

    obstacle_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .seed       (seed),
        .col_data   (col_data),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .pipe_count (pipe_count),
        .cur_spacing(cur_spacing),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] o,
                       input logic [15:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    task automatic model_reset(input logic [15:0] s);
        m_lfsr = (s == 16'd0) ? 16'hACE1 : s;
        m_idx  = 0;
        m_sp   = 6;
        m_ramp = 0;
        expq.delete();
    endtask

    // Reference generator: produces the next column of the ideal stream.
    task automatic gen_one();
        logic [6:0] raw;
        logic [6:0] c;
        if (m_idx == m_sp - 1) begin
            raw = m_lfsr[6:0];
            if (raw < 7'd8) c = 7'd8;
            else if (raw > 7'd60) c = 7'd60;
            else c = raw;
            m_lfsr = {m_lfsr[14:0],
                      m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_idx  = 0;
            m_ramp = m_ramp + 1;
            if (m_ramp == 8) begin
                m_ramp = 0;
                if (m_sp > 3) m_sp = m_sp - 1;
            end
        end else begin
            c     = 7'd0;
            m_idx = m_idx + 1;
        end
        expq.push_back(c);
    endtask

    task automatic peek(output logic [6:0] c);
        if (expq.size() == 0) gen_one();
        c = expq[0];
    endtask

    task automatic tick(input logic r, input logic s, input logic p);
        logic [6:0] e;
        @(negedge clk);
        start     = s;
        stop      = p;
        col_ready = r;
        popped    = 1'b0;
        if (col_valid && col_ready) begin
            if (expq.size() == 0) gen_one();
            e = expq.pop_front();
            chk("pop", {9'd0, col_data}, {9'd0, e});
            last_pop = col_data;
            popped   = 1'b1;
        end
    endtask

    task automatic pop_n(input int n);
        int got;
        int budget;
        got    = 0;
        budget = n * 4 + 20;
        while (got < n && budget > 0) begin
            tick(1'b1, 1'b0, 1'b0);
            if (popped) got++;
            budget--;
        end
        if (got < n) begin
            total++;
            bad++;
            $error("FAIL pop_timeout: got %0d want %0d", got, n);
        end
    endtask

    task automatic do_start(input logic [15:0] s);
        seed = s;
        tick(1'b0, 1'b1, 1'b0);
        model_reset(s);
    endtask

    initial begin
        logic [6:0] hd;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        seed      = 16'd0;
        col_ready = 1'b0;
        popped    = 1'b0;
        last_pop  = 7'd0;
        model_reset(16'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", {15'd0, col_valid}, 16'd0);
        chk("rst_data", {9'd0, col_data}, 16'd0);
        chk("rst_pipes", pipe_count, 16'd0);
        chk("rst_spacing", {12'd0, cur_spacing}, 16'd6);
        chk("rst_busy", {15'd0, busy}, 16'd0);

        // Continuous run, seed 1, through the ramp.
        do_start(16'h0001);
        tick(1'b1, 1'b0, 1'b0);
        chk("lat_valid0", {15'd0, col_valid}, 16'd0);
        chk("busy_run", {15'd0, busy}, 16'd1);
        tick(1'b1, 1'b0, 1'b0);
        chk("lat_valid1", {15'd0, col_valid}, 16'd1);
        pop_n(5);
        chk("first_pipe", {9'd0, last_pop}, 16'd8);
        pop_n(42);
        tick(1'b1, 1'b0, 1'b0);
        chk("pipes_8", pipe_count, 16'd8);
        chk("spacing_5", {12'd0, cur_spacing}, 16'd5);
        pop_n(250);
        chk("spacing_floor", {12'd0, cur_spacing}, 16'd3);

        // Backpressure stall with a pipe inside the full FIFO.
        do_start(16'h0001);
        pop_n(3);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        peek(hd);
        chk("stall_valid", {15'd0, col_valid}, 16'd1);
        chk("stall_pipes", pipe_count, 16'd1);
        chk("stall_head", {9'd0, col_data}, {9'd0, hd});
        pop_n(60);

        // Zero seed falls back to the default LFSR value.
        do_start(16'h0000);
        pop_n(6);
        chk("seed0_pipe", {9'd0, last_pop}, 16'd60);
        pop_n(20);

        // Stop mid-run, then restart.
        do_start(16'h0001);
        pop_n(20);
        tick(1'b0, 1'b0, 1'b1);
        expq.delete();
        tick(1'b0, 1'b0, 1'b0);
        chk("stop_valid", {15'd0, col_valid}, 16'd0);
        chk("stop_busy", {15'd0, busy}, 16'd0);
        chk("stop_pipes", pipe_count, 16'd3);
        do_start(16'h0001);
        tick(1'b1, 1'b0, 1'b0);
        chk("re_busy", {15'd0, busy}, 16'd1);
        chk("re_valid0", {15'd0, col_valid}, 16'd0);
        chk("re_pipes", pipe_count, 16'd0);
        chk("re_spacing", {12'd0, cur_spacing}, 16'd6);
        tick(1'b1, 1'b0, 1'b0);
        chk("re_valid1", {15'd0, col_valid}, 16'd1);
        pop_n(12);

        // Reset with a full FIFO.
        do_start(16'h0001);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        chk("full_valid", {15'd0, col_valid}, 16'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_valid", {15'd0, col_valid}, 16'd0);
        chk("mrst_data", {9'd0, col_data}, 16'd0);
        chk("mrst_pipes", pipe_count, 16'd0);
        chk("mrst_spacing", {12'd0, cur_spacing}, 16'd6);
        chk("mrst_busy", {15'd0, busy}, 16'd0);

        // Start together with stop while running restarts.
        do_start(16'h0005);
        pop_n(14);
        seed = 16'h1234;
        tick(1'b0, 1'b1, 1'b1);
        model_reset(16'h1234);
        tick(1'b1, 1'b0, 1'b0);
        chk("ss_busy", {15'd0, busy}, 16'd1);
        chk("ss_valid0", {15'd0, col_valid}, 16'd0);
        chk("ss_pipes", pipe_count, 16'd0);
        tick(1'b1, 1'b0, 1'b0);
        chk("ss_valid1", {15'd0, col_valid}, 16'd1);
        pop_n(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
